// File: rtl/cereal_arb_pkg.sv
// Shared types and constants for the cereal transmitter arbiter.
package cereal_arb_pkg;

  // Requester indices are always carried in 3 bits (N_REQ is at most 8).
  localparam int unsigned MaxReq = 8;
  localparam int unsigned IdxW   = 3;

  // One 8N1 frame at the default baud rate, and a counter wide enough for it.
  localparam int unsigned DefFrameCycles = 78105;
  localparam int unsigned DefCntW        = 17;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StHold
  } state_e;

  function automatic logic [MaxReq-1:0] onehot(input logic [IdxW-1:0] idx);
    logic [MaxReq-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/cereal_arbiter_rr_picker.sv
// Round-robin pick: first asserted request at or above ptr_i, modulo N_REQ.
module rr_picker
  import cereal_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [IdxW-1:0]  winner_o,
  output logic             valid_o
);

  // Scan N_REQ positions starting at the pointer; the first hit wins.
  always_comb begin
    int  idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    winner_o = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
      for (int j = 0; j < int'(N_REQ); j++) begin
        if (!found && idx == j && req_i[j]) begin
          winner_o = IdxW'(j);
          found    = 1'b1;
        end
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/cereal_arbiter.sv
// Round-robin arbiter sharing one serial transmitter, with per-requester
// lock so multi-byte strings from one producer are never interleaved.
module cereal_arbiter
  import cereal_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned FRAME_CYCLES = DefFrameCycles,
  parameter int unsigned CNT_W        = DefCntW
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   lock,
  input  logic [8*N_REQ-1:0] data_in,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   grant,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic               busy
);

  localparam logic [CNT_W-1:0] FrameLast = CNT_W'(FRAME_CYCLES - 1);

  state_e             state_q, state_d;
  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [IdxW-1:0]    owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;

  logic [IdxW-1:0]    pick_idx;
  logic               pick_valid;
  logic [N_REQ-1:0]   pick_oh;
  logic [7:0]         pick_byte;
  logic [7:0]         owner_byte;
  logic               owner_req;
  logic               owner_lock;
  logic [IdxW-1:0]    owner_next;

  rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (pick_idx),
    .valid_o  (pick_valid)
  );

  assign pick_oh = N_REQ'(onehot(pick_idx));

  // grant_q is one-hot on the owner, so masking with it selects the owner's bits.
  assign owner_req  = |(req & grant_q);
  assign owner_lock = |(lock & grant_q);
  assign owner_next = (owner_q == IdxW'(N_REQ - 1)) ? '0 : owner_q + IdxW'(1);

  // Byte slices for the arbitration winner and for the current owner.
  always_comb begin
    pick_byte  = '0;
    owner_byte = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (pick_idx == IdxW'(k)) pick_byte = data_in[8*k +: 8];
      if (owner_q == IdxW'(k)) owner_byte = data_in[8*k +: 8];
    end
  end

  // Next-state logic: accept, frame countdown, lock hold and release.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d    = StWait;
          owner_d    = pick_idx;
          grant_d    = pick_oh;
          ack_d      = pick_oh;
          tx_start_d = 1'b1;
          tx_data_d  = pick_byte;
          cnt_d      = FrameLast;
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (owner_lock && owner_req) begin
          // Locked owner with a byte ready: back-to-back frame, no re-arbitration.
          ack_d      = grant_q;
          tx_start_d = 1'b1;
          tx_data_d  = owner_byte;
          cnt_d      = FrameLast;
        end else if (owner_lock) begin
          state_d = StHold;
        end else begin
          state_d = StIdle;
          grant_d = '0;
          ptr_d   = owner_next;
        end
      end
      StHold: begin
        if (owner_lock && owner_req) begin
          state_d    = StWait;
          ack_d      = grant_q;
          tx_start_d = 1'b1;
          tx_data_d  = owner_byte;
          cnt_d      = FrameLast;
        end else if (!owner_lock) begin
          state_d = StIdle;
          grant_d = '0;
          ptr_d   = owner_next;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset; a reset mid-frame abandons it.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign ack      = ack_q;
  assign grant    = grant_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_cereal_arbiter.sv
// Scoreboard bench: stimulus pushes expected accepts (cycle, ack, byte),
// per-DUT monitors pop and compare on every tx_start.
module tb_cereal_arbiter;

  localparam int unsigned F4 = 16;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  ack;
    logic [7:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [3:0]  req4 = '0, lock4 = '0, ack4, grant4;
  logic [31:0] din4 = '0;
  logic        txs4, busy4;
  logic [7:0]  txd4;

  logic [2:0]  req3 = '0, lock3 = '0, ack3, grant3;
  logic [23:0] din3 = '0;
  logic        txs3, busy3;
  logic [7:0]  txd3;

  exp_t q4[$];
  exp_t q3[$];
  exp_t e4, e3;

  cereal_arbiter #(
    .N_REQ        (4),
    .FRAME_CYCLES (F4),
    .CNT_W        (5)
  ) dut (
    .sysclk   (clk),
    .rst      (rst),
    .req      (req4),
    .lock     (lock4),
    .data_in  (din4),
    .ack      (ack4),
    .grant    (grant4),
    .tx_start (txs4),
    .tx_data  (txd4),
    .busy     (busy4)
  );

  cereal_arbiter #(
    .N_REQ        (3),
    .FRAME_CYCLES (2),
    .CNT_W        (2)
  ) dut3 (
    .sysclk   (clk),
    .rst      (rst),
    .req      (req3),
    .lock     (lock3),
    .data_in  (din3),
    .ack      (ack3),
    .grant    (grant3),
    .tx_start (txs3),
    .tx_data  (txd3),
    .busy     (busy3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp4(input int unsigned at, input logic [3:0] a, input logic [7:0] d);
    q4.push_back('{cyc: at, ack: a, data: d});
  endtask

  task automatic exp3(input int unsigned at, input logic [2:0] a, input logic [7:0] d);
    q3.push_back('{cyc: at, ack: {1'b0, a}, data: d});
  endtask

  // Monitor for the 4-requester instance.
  always @(negedge clk) begin
    if (txs4 === 1'b1) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m4_unexpected_start: got tx_start=1 expected none at cycle %0d", cyc);
      end else begin
        e4 = q4.pop_front();
        check("m4_cycle", 32'(cyc), e4.cyc);
        check("m4_ack", 32'(ack4), 32'(e4.ack));
        check("m4_grant", 32'(grant4), 32'(e4.ack));
        check("m4_data", 32'(txd4), 32'(e4.data));
      end
    end else if (cyc > 2 && ack4 !== 4'b0) begin
      check("m4_ack_without_start", 32'(ack4), 32'd0);
    end
  end

  // Monitor for the 3-requester instance.
  always @(negedge clk) begin
    if (txs3 === 1'b1) begin
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m3_unexpected_start: got tx_start=1 expected none at cycle %0d", cyc);
      end else begin
        e3 = q3.pop_front();
        check("m3_cycle", 32'(cyc), e3.cyc);
        check("m3_ack", 32'(ack3), 32'(e3.ack));
        check("m3_grant", 32'(grant3), 32'(e3.ack));
        check("m3_data", 32'(txd3), 32'(e3.data));
      end
    end else if (cyc > 2 && ack3 !== 3'b0) begin
      check("m3_ack_without_start", 32'(ack3), 32'd0);
    end
  end

  initial begin
    int unsigned c;
    logic [7:0] hello [5];
    hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;

    // Reset state
    tick(2);
    check("rst_ack", 32'(ack4), 32'd0);
    check("rst_grant", 32'(grant4), 32'd0);
    check("rst_tx_start", 32'(txs4), 32'd0);
    check("rst_tx_data", 32'(txd4), 32'd0);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_busy3", 32'(busy3), 32'd0);
    rst = 1'b0;

    // N_REQ=3, FRAME_CYCLES=2: order 2,0,1 then 2,0 across the wrap
    c = cyc;
    din3 = {8'hC2, 8'hB1, 8'hA0};
    req3 = 3'b100;
    exp3(c + 1, 3'b100, 8'hC2);
    exp3(c + 4, 3'b001, 8'hA0);
    exp3(c + 7, 3'b010, 8'hB1);
    exp3(c + 10, 3'b100, 8'hC3);
    exp3(c + 13, 3'b001, 8'hA0);
    tick(1);
    req3 = 3'b011;
    tick(3);
    req3 = 3'b010;
    tick(3);
    din3[23:16] = 8'hC3;
    req3 = 3'b101;
    tick(3);
    req3 = 3'b001;
    tick(3);
    req3 = 3'b000;
    tick(4);

    // Single request, busy for exactly F4 cycles
    c = cyc;
    din4[7:0] = 8'h41;
    req4 = 4'b0001;
    exp4(c + 1, 4'b0001, 8'h41);
    tick(1);
    req4 = 4'b0000;
    tick(F4 - 1);
    check("single_busy_last", 32'(busy4), 32'd1);
    check("single_grant_last", 32'(grant4), 32'd1);
    tick(1);
    check("single_busy_end", 32'(busy4), 32'd0);
    check("single_grant_end", 32'(grant4), 32'd0);

    // Round robin from pointer 0 with req=1010: 1, 3, 1
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    c = cyc;
    din4[15:8] = 8'hB1;
    din4[31:24] = 8'hD3;
    req4 = 4'b1010;
    exp4(c + 1, 4'b0010, 8'hB1);
    exp4(c + 2 + F4, 4'b1000, 8'hD3);
    exp4(c + 3 + 2 * F4, 4'b0010, 8'hB1);
    tick(3 + 2 * F4);
    req4 = 4'b0000;
    tick(F4 + 1);
    check("rr_idle", 32'(busy4), 32'd0);

    // Locked string from requester 2 while requester 0 waits
    c = cyc;
    din4[7:0] = 8'h30;
    din4[23:16] = hello[0];
    req4 = 4'b0101;
    lock4 = 4'b0100;
    for (int k = 0; k < 5; k++) exp4(c + 1 + k * F4, 4'b0100, hello[k]);
    exp4(c + 2 + 5 * F4, 4'b0001, 8'h30);
    tick(1);
    for (int k = 1; k < 5; k++) begin
      din4[23:16] = hello[k];
      tick(F4);
    end
    lock4 = 4'b0000;
    req4 = 4'b0001;
    tick(F4 + 1);
    req4 = 4'b0000;
    tick(F4 + 1);

    // HOLD: requester 1 locked with no byte, one accept from HOLD, then release
    c = cyc;
    din4[15:8] = 8'h61;
    req4 = 4'b0010;
    lock4 = 4'b0010;
    exp4(c + 1, 4'b0010, 8'h61);
    tick(1);
    req4 = 4'b0000;
    tick(F4);
    check("hold_busy", 32'(busy4), 32'd1);
    check("hold_grant", 32'(grant4), 32'h2);
    tick(2);
    check("hold_grant_kept", 32'(grant4), 32'h2);
    din4[15:8] = 8'h62;
    req4 = 4'b0010;
    exp4(c + 4 + F4, 4'b0010, 8'h62);
    tick(1);
    req4 = 4'b0000;
    tick(F4);
    check("hold2_grant", 32'(grant4), 32'h2);
    lock4 = 4'b0000;
    tick(1);
    check("release_grant", 32'(grant4), 32'd0);
    check("release_busy", 32'(busy4), 32'd0);

    // Reset mid-frame, pending request then served from pointer 0
    c = cyc;
    din4[31:24] = 8'h33;
    din4[7:0] = 8'h5A;
    req4 = 4'b1000;
    exp4(c + 1, 4'b1000, 8'h33);
    tick(1);
    req4 = 4'b1001;
    tick(5);
    check("midframe_busy", 32'(busy4), 32'd1);
    rst = 1'b1;
    tick(1);
    check("mrst_ack", 32'(ack4), 32'd0);
    check("mrst_grant", 32'(grant4), 32'd0);
    check("mrst_tx_start", 32'(txs4), 32'd0);
    check("mrst_tx_data", 32'(txd4), 32'd0);
    check("mrst_busy", 32'(busy4), 32'd0);
    rst = 1'b0;
    exp4(c + 8, 4'b0001, 8'h5A);
    tick(1);
    req4 = 4'b0000;
    tick(F4 + 4);

    check("q4_drained", 32'(q4.size()), 32'd0);
    check("q3_drained", 32'(q3.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
